// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder.
// Operands and strobe flow master->slave; status and result flow back.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, registered carry,
// LSB first, WIDTH cycles per operation plus a one-cycle done state.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_d;
    logic             c;
    logic             s;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             load;
    logic             step;
    logic             last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        load    = 1'b0;
        step    = 1'b0;
        last    = (cnt == LAST);
        s       = a_sh[0] ^ b_sh[0] ^ c;
        cy      = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        acc_d   = {s, acc[WIDTH-1:1]};
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // back-to-back start is taken straight from the done cycle
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
        end else if (load) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            c    <= bus.cin;
            cnt  <= '0;
        end else if (step) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            c    <= cy;
            acc  <= acc_d;
            if (last) begin
                bus.sum  <= acc_d;
                bus.cout <= cy;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 (directed + random)
// and WIDTH=13 (random), both running concurrently.
module tb_serial_adder;
    logic clk;
    logic rst8;
    logic rst13;
    int   checks;
    int   errors;
    bit   fin13;

    logic [8:0]  q8[$];
    logic [13:0] q13[$];

    serial_adder_if #(.WIDTH(8))  i8 ();
    serial_adder_if #(.WIDTH(13)) i13 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk),
        .rst(rst8),
        .bus(i8)
    );

    serial_adder #(.WIDTH(13)) dut13 (
        .clk(clk),
        .rst(rst13),
        .bus(i13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (i8.busy && i8.done) chk("busy_and_done8", 1'b1, 1'b0);
        if (i8.done) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", i8.done, 1'b0);
            end else begin
                chk("result8", {i8.cout, i8.sum}, q8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (i13.busy && i13.done) chk("busy_and_done13", 1'b1, 1'b0);
        if (i13.done) begin
            if (q13.size() == 0) begin
                chk("unexpected_done13", i13.done, 1'b0);
            end else begin
                chk("result13", {i13.cout, i13.sum}, q13.pop_front());
            end
        end
    end

    // Called just after a rising edge; start is sampled on the next one.
    task automatic go8(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input bit push);
        i8.start = 1'b1;
        i8.a     = a;
        i8.b     = b;
        i8.cin   = c;
        if (push) q8.push_back(9'(a) + 9'(b) + 9'(c));
        @(posedge clk);
        #1;
        i8.start = 1'b0;
        i8.a     = 8'($urandom);
        i8.b     = 8'($urandom);
        i8.cin   = 1'($urandom);
    endtask

    task automatic wait_done8(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("busy8", i8.busy, 1'b1);
            chk("done_low8", i8.done, 1'b0);
        end
        @(negedge clk);
        chk("done8", i8.done, 1'b1);
        chk("busy_low8", i8.busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [12:0] a;
        logic [12:0] b;
        logic        c;
        fin13     = 1'b0;
        rst13     = 1'b1;
        i13.start = 1'b0;
        i13.a     = '0;
        i13.b     = '0;
        i13.cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst13 = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            a = 13'($urandom);
            b = 13'($urandom);
            c = 1'($urandom);
            if (k == 0) begin
                a = '1;
                b = '1;
                c = 1'b1;
            end
            i13.start = 1'b1;
            i13.a     = a;
            i13.b     = b;
            i13.cin   = c;
            q13.push_back(14'(a) + 14'(b) + 14'(c));
            @(posedge clk);
            #1;
            i13.start = 1'b0;
            i13.a     = 13'($urandom);
            repeat (13) @(negedge clk);
            chk("busy13", i13.busy, 1'b1);
            @(negedge clk);
            chk("done13", i13.done, 1'b1);
            @(posedge clk);
            #1;
        end
        fin13 = 1'b1;
    end

    initial begin
        int n;
        checks   = 0;
        errors   = 0;
        rst8     = 1'b1;
        i8.start = 1'b0;
        i8.a     = '0;
        i8.b     = '0;
        i8.cin   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", i8.busy, 1'b0);
        chk("rst_done", i8.done, 1'b0);
        chk("rst_sum", i8.sum, 8'h00);
        chk("rst_cout", i8.cout, 1'b0);
        rst8 = 1'b0;

        go8(8'h5A, 8'h3C, 1'b0, 1'b1);
        wait_done8(8);
        go8(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_done8(8);
        go8(8'hFF, 8'hFF, 1'b1, 1'b1);
        wait_done8(8);

        // restart during RUN must be ignored
        go8(8'h12, 8'h34, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        i8.start = 1'b1;
        i8.a     = 8'hEE;
        i8.b     = 8'h77;
        @(posedge clk);
        #1;
        i8.start = 1'b0;
        wait_done8(5);

        // start held high: a result every 9 cycles
        i8.start = 1'b1;
        i8.a     = 8'h10;
        i8.b     = 8'h20;
        i8.cin   = 1'b0;
        repeat (3) q8.push_back(9'h030);
        @(posedge clk);
        #1;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            chk("hold_busy", i8.busy, (i % 9) != 8);
            chk("hold_done", i8.done, (i % 9) == 8);
            if (i == 20) i8.start = 1'b0;
        end
        @(posedge clk);
        repeat (3) @(negedge clk);
        chk("sum_hold", i8.sum, 8'h30);
        chk("idle_busy", i8.busy, 1'b0);
        @(posedge clk);
        #1;

        // reset mid-RUN discards the operation
        go8(8'hC3, 8'h5F, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        rst8 = 1'b0;
        chk("abort_busy", i8.busy, 1'b0);
        chk("abort_done", i8.done, 1'b0);
        chk("abort_sum", i8.sum, 8'h00);
        chk("abort_cout", i8.cout, 1'b0);
        repeat (12) begin
            @(negedge clk);
            chk("abort_quiet", i8.done, 1'b0);
        end
        @(posedge clk);
        #1;
        go8(8'h01, 8'h01, 1'b0, 1'b1);
        wait_done8(8);

        for (int k = 0; k < 1000; k++) begin
            go8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            wait_done8(8);
        end

        n = 0;
        while (!fin13 && n < 50000) begin
            @(posedge clk);
            n++;
        end
        chk("finish13", fin13, 1'b1);
        repeat (2) @(negedge clk);
        chk("q8_empty", q8.size(), 0);
        chk("q13_empty", q13.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
